// File: rtl/timer_preset_bank_pkg.sv
// -----------------------------------------------------------------------------
// timer_preset_bank_pkg
// Shared definitions for the preset bank: FSM state encoding, edit-field
// encoding, the bit widths of the hour/minute/second fields and small helpers
// used by the interface and the RTL.
// -----------------------------------------------------------------------------
package timer_preset_bank_pkg;

   // Settings FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEL_CH = 2'd1,
      EDIT   = 2'd2
   } state_e;

   // Field currently targeted by inc/dec
   typedef enum logic [1:0] {
      F_HOUR = 2'd0,
      F_MIN  = 2'd1,
      F_SEC  = 2'd2
   } field_e;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   // Channel index width: max(1, clog2(n))
   function automatic int chw(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Field rotation H -> M -> S -> H
   function automatic field_e next_field(input field_e f);
      field_e r;
      case (f)
         F_HOUR:  r = F_MIN;
         F_MIN:   r = F_SEC;
         default: r = F_HOUR;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/timer_preset_bank_if.sv
// -----------------------------------------------------------------------------
// timer_preset_bank_if
// Bundles the button pulses coming from the debounced front-end with the
// status, shadow and flat preset buses read by the mode controllers and the
// seven-segment driver.
//   master : button/enable driver (front-end or bench)
//   slave  : timer_preset_bank itself
// Flat preset buses place channel k at [W*k +: W].
// -----------------------------------------------------------------------------
interface timer_preset_bank_if
   import timer_preset_bank_pkg::*;
#(
   parameter int N_CH = 3
);
   localparam int CHW = chw(N_CH);

   logic                     enable;
   logic                     ch_next;
   logic                     field_next;
   logic                     inc;
   logic                     dec;
   logic                     confirm;
   logic                     cancel;
   logic                     init;

   logic                     in_settings_mode;
   logic                     in_edit;
   logic [CHW-1:0]           edit_ch;
   logic [1:0]               edit_field;
   logic [HOUR_W-1:0]        shadow_h;
   logic [MIN_W-1:0]         shadow_m;
   logic [SEC_W-1:0]         shadow_s;
   logic [HOUR_W*N_CH-1:0]   preset_hour;
   logic [MIN_W*N_CH-1:0]    preset_min;
   logic [SEC_W*N_CH-1:0]    preset_sec;
   logic                     commit_pulse;

   modport master (
      output enable, ch_next, field_next, inc, dec, confirm, cancel, init,
      input  in_settings_mode, in_edit, edit_ch, edit_field,
             shadow_h, shadow_m, shadow_s,
             preset_hour, preset_min, preset_sec, commit_pulse
   );

   modport slave (
      input  enable, ch_next, field_next, inc, dec, confirm, cancel, init,
      output in_settings_mode, in_edit, edit_ch, edit_field,
             shadow_h, shadow_m, shadow_s,
             preset_hour, preset_min, preset_sec, commit_pulse
   );

endinterface

// File: rtl/timer_preset_bank_preset_field_counter.sv
// -----------------------------------------------------------------------------
// preset_field_counter
// Modulo up/down register for one time field (range 0..MAX).
//   clk, rst_n : clock, async active-low reset (value clears to 0)
//   load       : take load_val (wins over inc/dec)
//   load_val   : value to load
//   inc / dec  : +1 / -1 with wrap; both together hold the value
//   value      : registered field value
// -----------------------------------------------------------------------------
module preset_field_counter #(
   parameter int MAX = 59,
   parameter int W   = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value
);

   logic [W-1:0] val_q;
   logic [W-1:0] val_d;

   // Next value: load, wrap-around increment/decrement, or hold
   always_comb begin
      val_d = val_q;
      if (load) begin
         val_d = load_val;
      end else if (inc && !dec) begin
         val_d = (val_q == W'(MAX)) ? '0 : val_q + W'(1);
      end else if (dec && !inc) begin
         val_d = (val_q == '0) ? W'(MAX) : val_q - W'(1);
      end else begin
         val_d = val_q;
      end
   end

   // Field register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign value = val_q;

endmodule

// File: rtl/timer_preset_bank.sv
// -----------------------------------------------------------------------------
// timer_preset_bank
// Bank of N_CH hour:min:sec presets with a button-driven select/edit FSM.
// A shadow copy of the selected channel is edited and written back on
// confirm, or abandoned on cancel / enable drop / init.
//   clk, rst_n : clock, async active-low reset
//   bus        : timer_preset_bank_if slave (buttons in; status, shadow and
//                flat preset buses out, all registered)
// Per-cycle priority: init > enable low > cancel > confirm > field_next >
// inc/dec; in SEL_CH confirm takes precedence over ch_next.
// -----------------------------------------------------------------------------
module timer_preset_bank
   import timer_preset_bank_pkg::*;
#(
   parameter int N_CH     = 3,
   parameter int HOUR_MAX = 23,
   parameter int MIN_MAX  = 59,
   parameter int SEC_MAX  = 59,
   parameter int DEF_H    = 0,
   parameter int DEF_M    = 1,
   parameter int DEF_S    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   timer_preset_bank_if.slave bus
);

   localparam int CHW = chw(N_CH);

   state_e            state_q, state_d;
   logic              in_settings_q, in_settings_d;
   logic              in_edit_q, in_edit_d;
   logic [CHW-1:0]    edit_ch_q, edit_ch_d;
   field_e            edit_field_q, edit_field_d;
   logic              commit_pulse_q, commit_pulse_d;

   // Decoded single action for this cycle
   logic              act_sel_confirm;
   logic              act_ch_next;
   logic              act_cancel;
   logic              act_commit;
   logic              act_field_next;
   logic              act_incdec;

   logic [HOUR_W*N_CH-1:0] bank_h_flat;
   logic [MIN_W*N_CH-1:0]  bank_m_flat;
   logic [SEC_W*N_CH-1:0]  bank_s_flat;

   logic [HOUR_W-1:0] shadow_h;
   logic [MIN_W-1:0]  shadow_m;
   logic [SEC_W-1:0]  shadow_s;
   logic [HOUR_W-1:0] sel_h;
   logic [MIN_W-1:0]  sel_m;
   logic [SEC_W-1:0]  sel_s;

   // Pick the one action that wins this cycle
   always_comb begin
      act_sel_confirm = 1'b0;
      act_ch_next     = 1'b0;
      act_cancel      = 1'b0;
      act_commit      = 1'b0;
      act_field_next  = 1'b0;
      act_incdec      = 1'b0;
      if (bus.init || !bus.enable) begin
         act_sel_confirm = 1'b0;
      end else begin
         case (state_q)
            SEL_CH: begin
               if (bus.confirm) begin
                  act_sel_confirm = 1'b1;
               end else if (bus.ch_next) begin
                  act_ch_next = 1'b1;
               end else begin
                  act_ch_next = 1'b0;
               end
            end
            EDIT: begin
               if (bus.cancel) begin
                  act_cancel = 1'b1;
               end else if (bus.confirm) begin
                  act_commit = 1'b1;
               end else if (bus.field_next) begin
                  act_field_next = 1'b1;
               end else begin
                  act_incdec = 1'b1;
               end
            end
            default: begin
               act_sel_confirm = 1'b0;
            end
         endcase
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      if (bus.init) begin
         state_d = bus.enable ? SEL_CH : IDLE;
      end else if (!bus.enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = SEL_CH;
            SEL_CH:  state_d = act_sel_confirm ? EDIT : SEL_CH;
            EDIT:    state_d = (act_cancel || act_commit) ? SEL_CH : EDIT;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs, computed from the next state so they register in step
   always_comb begin
      in_settings_d = (state_d != IDLE);
      in_edit_d     = (state_d == EDIT);
   end

   // FSM state and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         in_settings_q <= 1'b0;
         in_edit_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_settings_q <= in_settings_d;
         in_edit_q     <= in_edit_d;
      end
   end

   // Channel select, field select and commit strobe
   always_comb begin
      edit_ch_d      = edit_ch_q;
      edit_field_d   = edit_field_q;
      commit_pulse_d = act_commit;
      if (act_ch_next) begin
         edit_ch_d = (edit_ch_q == CHW'(N_CH - 1)) ? '0 : edit_ch_q + CHW'(1);
      end else begin
         edit_ch_d = edit_ch_q;
      end
      if (act_sel_confirm) begin
         edit_field_d = F_HOUR;
      end else if (act_field_next) begin
         edit_field_d = next_field(edit_field_q);
      end else begin
         edit_field_d = edit_field_q;
      end
   end

   // Selection registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edit_ch_q      <= '0;
         edit_field_q   <= F_HOUR;
         commit_pulse_q <= 1'b0;
      end else begin
         edit_ch_q      <= edit_ch_d;
         edit_field_q   <= edit_field_d;
         commit_pulse_q <= commit_pulse_d;
      end
   end

   // Currently selected bank entry, source for the shadow load
   always_comb begin
      sel_h = bank_h_flat[edit_ch_q*HOUR_W +: HOUR_W];
      sel_m = bank_m_flat[edit_ch_q*MIN_W +: MIN_W];
      sel_s = bank_s_flat[edit_ch_q*SEC_W +: SEC_W];
   end

   preset_field_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_shadow_h (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (act_sel_confirm),
      .load_val (sel_h),
      .inc      (act_incdec && (edit_field_q == F_HOUR) && bus.inc),
      .dec      (act_incdec && (edit_field_q == F_HOUR) && bus.dec),
      .value    (shadow_h)
   );

   preset_field_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_shadow_m (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (act_sel_confirm),
      .load_val (sel_m),
      .inc      (act_incdec && (edit_field_q == F_MIN) && bus.inc),
      .dec      (act_incdec && (edit_field_q == F_MIN) && bus.dec),
      .value    (shadow_m)
   );

   preset_field_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_shadow_s (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (act_sel_confirm),
      .load_val (sel_s),
      .inc      (act_incdec && (edit_field_q == F_SEC) && bus.inc),
      .dec      (act_incdec && (edit_field_q == F_SEC) && bus.dec),
      .value    (shadow_s)
   );

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [HOUR_W-1:0] h_q, h_d;
      logic [MIN_W-1:0]  m_q, m_d;
      logic [SEC_W-1:0]  s_q, s_d;

      // Channel entry update: defaults on init, shadow on a commit to this channel
      always_comb begin
         if (bus.init) begin
            h_d = HOUR_W'(DEF_H);
            m_d = MIN_W'(DEF_M);
            s_d = SEC_W'(DEF_S);
         end else if (act_commit && (edit_ch_q == CHW'(k))) begin
            h_d = shadow_h;
            m_d = shadow_m;
            s_d = shadow_s;
         end else begin
            h_d = h_q;
            m_d = m_q;
            s_d = s_q;
         end
      end

      // Channel entry registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            h_q <= HOUR_W'(DEF_H);
            m_q <= MIN_W'(DEF_M);
            s_q <= SEC_W'(DEF_S);
         end else begin
            h_q <= h_d;
            m_q <= m_d;
            s_q <= s_d;
         end
      end

      assign bank_h_flat[k*HOUR_W +: HOUR_W] = h_q;
      assign bank_m_flat[k*MIN_W +: MIN_W]   = m_q;
      assign bank_s_flat[k*SEC_W +: SEC_W]   = s_q;
   end

   assign bus.in_settings_mode = in_settings_q;
   assign bus.in_edit          = in_edit_q;
   assign bus.edit_ch          = edit_ch_q;
   assign bus.edit_field       = edit_field_q;
   assign bus.shadow_h         = shadow_h;
   assign bus.shadow_m         = shadow_m;
   assign bus.shadow_s         = shadow_s;
   assign bus.preset_hour      = bank_h_flat;
   assign bus.preset_min       = bank_m_flat;
   assign bus.preset_sec       = bank_s_flat;
   assign bus.commit_pulse     = commit_pulse_q;

endmodule

// File: tb/tb_timer_preset_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_preset_bank
// Directed bench for timer_preset_bank. A 3-channel DUT is checked every
// cycle against a behavioural model; a 5-channel DUT shares the stimulus and
// has its channel select and edit status checked against the same model.
// -----------------------------------------------------------------------------
module tb_timer_preset_bank;

   localparam logic [6:0] P_NONE = 7'd0;
   localparam logic [6:0] P_CN   = 7'd1;
   localparam logic [6:0] P_FN   = 7'd2;
   localparam logic [6:0] P_INC  = 7'd4;
   localparam logic [6:0] P_DEC  = 7'd8;
   localparam logic [6:0] P_CF   = 7'd16;
   localparam logic [6:0] P_CC   = 7'd32;
   localparam logic [6:0] P_IT   = 7'd64;

   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   timer_preset_bank_if #(.N_CH(3)) bus_a ();
   timer_preset_bank_if #(.N_CH(5)) bus_b ();

   timer_preset_bank #(.N_CH(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   timer_preset_bank #(.N_CH(5)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   assign bus_b.enable     = bus_a.enable;
   assign bus_b.ch_next    = bus_a.ch_next;
   assign bus_b.field_next = bus_a.field_next;
   assign bus_b.inc        = bus_a.inc;
   assign bus_b.dec        = bus_a.dec;
   assign bus_b.confirm    = bus_a.confirm;
   assign bus_b.cancel     = bus_a.cancel;
   assign bus_b.init       = bus_a.init;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 choosing a channel, 2 editing
   int m_mode;
   int m_ch;
   int m_chb;
   int m_field;
   int m_commit;
   int m_bank [3][3];
   int m_sh [3];
   int mods [3] = '{24, 60, 60};
   int defs [3] = '{0, 1, 0};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_defaults();
      for (int c = 0; c < 3; c++)
         for (int f = 0; f < 3; f++)
            m_bank[c][f] = defs[f];
   endtask

   task automatic model_reset();
      model_defaults();
      m_mode = 0; m_ch = 0; m_chb = 0; m_field = 0; m_commit = 0;
      for (int f = 0; f < 3; f++) m_sh[f] = 0;
   endtask

   task automatic model_step();
      m_commit = 0;
      if (bus_a.init) begin
         model_defaults();
         m_mode = bus_a.enable ? 1 : 0;
      end else if (!bus_a.enable) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (bus_a.confirm) begin
            for (int f = 0; f < 3; f++) m_sh[f] = m_bank[m_ch][f];
            m_field = 0;
            m_mode = 2;
         end else if (bus_a.ch_next) begin
            m_ch  = (m_ch + 1) % 3;
            m_chb = (m_chb + 1) % 5;
         end
      end else begin
         if (bus_a.cancel) begin
            m_mode = 1;
         end else if (bus_a.confirm) begin
            for (int f = 0; f < 3; f++) m_bank[m_ch][f] = m_sh[f];
            m_commit = 1;
            m_mode = 1;
         end else if (bus_a.field_next) begin
            m_field = (m_field + 1) % 3;
         end else if (bus_a.inc && !bus_a.dec) begin
            m_sh[m_field] = (m_sh[m_field] + 1) % mods[m_field];
         end else if (bus_a.dec && !bus_a.inc) begin
            m_sh[m_field] = (m_sh[m_field] + mods[m_field] - 1) % mods[m_field];
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      chk("in_settings_mode", bus_a.in_settings_mode, m_mode != 0);
      chk("in_edit", bus_a.in_edit, m_mode == 2);
      chk("edit_ch", bus_a.edit_ch, m_ch);
      chk("edit_field", bus_a.edit_field, m_field);
      chk("shadow_h", bus_a.shadow_h, m_sh[0]);
      chk("shadow_m", bus_a.shadow_m, m_sh[1]);
      chk("shadow_s", bus_a.shadow_s, m_sh[2]);
      chk("commit_pulse", bus_a.commit_pulse, m_commit);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("ch%0d_hour", c), bus_a.preset_hour[c*5 +: 5], m_bank[c][0]);
         chk($sformatf("ch%0d_min", c), bus_a.preset_min[c*6 +: 6], m_bank[c][1]);
         chk($sformatf("ch%0d_sec", c), bus_a.preset_sec[c*6 +: 6], m_bank[c][2]);
      end
      chk("b_edit_ch", bus_b.edit_ch, m_chb);
      chk("b_in_edit", bus_b.in_edit, m_mode == 2);
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic [6:0] p);
      bus_a.ch_next    = p[0];
      bus_a.field_next = p[1];
      bus_a.inc        = p[2];
      bus_a.dec        = p[3];
      bus_a.confirm    = p[4];
      bus_a.cancel     = p[5];
      bus_a.init       = p[6];
      @(posedge clk);
      #1;
      bus_a.ch_next    = 1'b0;
      bus_a.field_next = 1'b0;
      bus_a.inc        = 1'b0;
      bus_a.dec        = 1'b0;
      bus_a.confirm    = 1'b0;
      bus_a.cancel     = 1'b0;
      bus_a.init       = 1'b0;
   endtask

   task automatic stepn(input logic [6:0] p, input int n);
      for (int i = 0; i < n; i++) step(p);
   endtask

   task automatic chk_all_default(input string tag);
      for (int c = 0; c < 3; c++) begin
         chk({tag, "_h"}, bus_a.preset_hour[c*5 +: 5], 0);
         chk({tag, "_m"}, bus_a.preset_min[c*6 +: 6], 1);
         chk({tag, "_s"}, bus_a.preset_sec[c*6 +: 6], 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus_a.enable = 1'b0;
      bus_a.ch_next = 1'b0; bus_a.field_next = 1'b0; bus_a.inc = 1'b0;
      bus_a.dec = 1'b0; bus_a.confirm = 1'b0; bus_a.cancel = 1'b0; bus_a.init = 1'b0;
      #22 rst_n = 1'b1;
      @(posedge clk); #1;
      step(P_NONE); step(P_NONE);

      // 1: reset values
      chk_all_default("rst_default");
      chk("rst_in_settings", bus_a.in_settings_mode, 0);
      chk("rst_commit", bus_a.commit_pulse, 0);

      // 2: edit ch2 to 03:00:00
      bus_a.enable = 1'b1;
      step(P_NONE);
      chk("en_in_settings", bus_a.in_settings_mode, 1);
      stepn(P_CN, 2);
      chk("sel_ch2", bus_a.edit_ch, 2);
      step(P_CF);
      chk("enter_edit", bus_a.in_edit, 1);
      stepn(P_INC, 3); step(P_FN); step(P_DEC);
      step(P_CF);
      chk("commit_hi", bus_a.commit_pulse, 1);
      chk("ch2_hour_lit", bus_a.preset_hour[14:10], 3);
      chk("ch2_min_lit", bus_a.preset_min[17:12], 0);
      chk("model_ch2_hour_lit", m_bank[2][0], 3);
      chk("model_ch2_min_lit", m_bank[2][1], 0);
      chk("ch0_min_kept", bus_a.preset_min[5:0], 1);
      chk("ch1_min_kept", bus_a.preset_min[11:6], 1);
      step(P_NONE);
      chk("commit_lo", bus_a.commit_pulse, 0);
      chk("back_sel", bus_a.in_settings_mode && !bus_a.in_edit, 1);

      // 3: field wrap on ch0
      step(P_CN);
      chk("sel_ch0", bus_a.edit_ch, 0);
      step(P_CF); step(P_FN); step(P_FN);
      step(P_DEC);
      chk("sec_wrap_down", bus_a.shadow_s, 59);
      step(P_INC);
      chk("sec_wrap_up", bus_a.shadow_s, 0);
      step(P_FN);
      chk("field_wrap", bus_a.edit_field, 0);
      step(P_DEC);
      chk("hour_wrap_down", bus_a.shadow_h, 23);
      chk("model_hour_wrap_lit", m_sh[0], 23);
      step(P_CC);
      chk("ch0_after_cancel", bus_a.preset_hour[4:0], 0);

      // 4: cancel and enable drop on ch1
      step(P_CN); step(P_CF); stepn(P_INC, 5);
      chk("ch1_shadow5", bus_a.shadow_h, 5);
      step(P_CC);
      chk("cancel_no_commit", bus_a.commit_pulse, 0);
      chk("cancel_ch1_hour", bus_a.preset_hour[9:5], 0);
      chk("cancel_not_edit", bus_a.in_edit, 0);
      step(P_CF); stepn(P_INC, 5);
      bus_a.enable = 1'b0;
      step(P_NONE);
      chk("disable_idle", bus_a.in_settings_mode, 0);
      chk("disable_ch1_hour", bus_a.preset_hour[9:5], 0);
      chk("disable_keeps_ch", bus_a.edit_ch, 1);

      // 5: commit then init with pending edit
      bus_a.enable = 1'b1;
      step(P_NONE); step(P_CN); step(P_CN);
      chk("sel_ch0_again", bus_a.edit_ch, 0);
      step(P_CF); stepn(P_INC, 2); step(P_CF);
      chk("ch0_hour2", bus_a.preset_hour[4:0], 2);
      chk("ch0_min1", bus_a.preset_min[5:0], 1);
      step(P_CF); step(P_INC);
      chk("pending_h3", bus_a.shadow_h, 3);
      step(P_IT);
      chk_all_default("init_default");
      chk("init_sel", bus_a.in_settings_mode && !bus_a.in_edit, 1);
      chk("init_no_commit", bus_a.commit_pulse, 0);

      // 6: simultaneous pulses
      step(P_CF);
      step(P_INC | P_DEC);
      chk("incdec_hold", bus_a.shadow_h, 0);
      step(P_INC);
      chk("inc_after_hold", bus_a.shadow_h, 1);
      step(P_CF | P_CC);
      chk("cancel_wins_edit", bus_a.in_edit, 0);
      chk("cancel_wins_commit", bus_a.commit_pulse, 0);
      chk("cancel_wins_bank", bus_a.preset_hour[4:0], 0);

      // 1b: async reset in the middle of an edit
      step(P_CF); step(P_INC); step(P_CF);
      chk("pre_rst_ch0_hour", bus_a.preset_hour[4:0], 1);
      step(P_CF); step(P_INC);
      chk("pre_rst_edit", bus_a.in_edit, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_in_edit", bus_a.in_edit, 0);
      chk("async_in_settings", bus_a.in_settings_mode, 0);
      chk("async_ch0_hour", bus_a.preset_hour[4:0], 0);
      chk("async_shadow_h", bus_a.shadow_h, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_sel", bus_a.in_settings_mode, 1);

      // 6b: channel wrap with 3 and 5 channels
      stepn(P_CN, 5);
      chk("n5_wrap", bus_b.edit_ch, 0);
      chk("n3_wrap", bus_a.edit_ch, 2);
      step(P_NONE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_preset_bank.md
Name: timer_preset_bank

Overview:
Parametrised successor to the range-hood advanced-settings block. It holds N_CH independent hour:min:sec presets (clean, gesture, system-time and future modes). A button-driven select/edit FSM edits a shadow copy and commits it on confirm, or discards it on cancel. It sits between the debounced button front-end and the mode controllers and seven-segment driver. Those consumers read the flat preset buses and the live shadow value.

Parameters:
N_CH, 3, number of preset channels (>=2)
HOUR_MAX, 23, hour field modulus-1
MIN_MAX, 59, minute field modulus-1
SEC_MAX, 59, second field modulus-1
DEF_H, 0, hour loaded on reset and on init
DEF_M, 1, minute loaded on reset and on init
DEF_S, 0, second loaded on reset and on init

Ports:
clk  in  1  system clock; one clock domain
rst_n  in  1  asynchronous, active-low reset
enable  in  1  level; settings mode active
ch_next  in  1  single-cycle pulse; next channel (SEL_CH only)
field_next  in  1  single-cycle pulse; next field, H->M->S->H (EDIT only)
inc  in  1  single-cycle pulse; field +1 (EDIT only)
dec  in  1  single-cycle pulse; field -1 (EDIT only)
confirm  in  1  single-cycle pulse; SEL_CH enters EDIT; EDIT commits
cancel  in  1  single-cycle pulse; EDIT discards
init  in  1  single-cycle pulse; restore all defaults
in_settings_mode  out  1  high in SEL_CH or EDIT
in_edit  out  1  high in EDIT
edit_ch  out  CHW  selected channel; CHW = max(1, clog2(N_CH))
edit_field  out  2  0=hour, 1=min, 2=sec
shadow_h / shadow_m / shadow_s  out  5/6/6  live value being edited
preset_hour  out  5*N_CH  channel k at [5k+4:5k]
preset_min  out  6*N_CH  channel k at [6k+5:6k]
preset_sec  out  6*N_CH  channel k at [6k+5:6k]
commit_pulse  out  1  one-cycle pulse on a successful commit

Behaviour:
- Reset (async, rst_n=0) sets: every channel = DEF_H:DEF_M:DEF_S, state IDLE, edit_ch=0, edit_field=0, shadow=0, commit_pulse=0, in_settings_mode=0, in_edit=0.
- All outputs are registered. A pulse sampled at edge t takes visible effect after edge t.
- States:
  - IDLE: enable=1 -> SEL_CH.
  - SEL_CH: ch_next advances edit_ch, wrapping N_CH-1 -> 0. confirm loads the shadow from bank[edit_ch], sets edit_field=0 and goes to EDIT.
  - EDIT:
    - inc/dec modify the selected shadow field modulo its MAX+1; HOUR_MAX+1 -> 0 and 0-1 -> HOUR_MAX, same rule for min/sec.
    - field_next advances field 0->1->2->0.
    - confirm writes the shadow to bank[edit_ch], pulses commit_pulse for exactly one cycle and returns to SEL_CH.
    - cancel discards the shadow and returns to SEL_CH.
- Pulses not valid in the current state are ignored.
- Priority per cycle, highest first: init > enable=0 > cancel > confirm > field_next > inc/dec. Only the highest-priority pulse acts.
- inc and dec together: no change.
- init in any state: all channels = defaults and the shadow is discarded. Next state is SEL_CH if enable=1, else IDLE. No commit_pulse.
- enable=0 in any state: IDLE on the next cycle and the shadow is discarded. The bank is unchanged; edit_ch is kept.
- The bank only changes on reset, init or EDIT confirm. Non-edited channels never change during an edit.
- Shadow outputs hold their last value outside EDIT.

Decomposition:
- Shared package: state encoding (IDLE/SEL_CH/EDIT), field encoding (F_HOUR/F_MIN/F_SEC), field widths (5/6/6).
- Sub-module: preset_field_counter, a modulo up/down register with parameter MAX. It has load, inc and dec inputs; simultaneous inc+dec holds the value. It is instantiated three times for the shadow.
- The bank is a generate loop of N_CH register triples.

Test Plan:
1. Reset, then release -> every channel reads 00:01:00; in_settings_mode=0, commit_pulse=0. Assert rst_n mid-EDIT -> defaults and IDLE immediately, without waiting for a clock edge.
2. enable=1, ch_next x2, confirm, inc x3, field_next, dec, confirm -> ch2 = 03:00:00, one-cycle commit_pulse, ch0/ch1 stay 00:01:00, back in SEL_CH.
3. Edit ch0: field_next x2 then dec -> shadow_s=59; then inc -> 0. Return to hour field, dec from 0 -> 23.
4. Edit ch1 with hour inc x5:
   - then cancel -> ch1 stays 00:01:00, no commit_pulse;
   - repeat, then drop enable -> IDLE, bank unchanged.
5. Commit ch0 = 02:01:00, re-enter EDIT with a pending change, pulse init -> all channels 00:01:00, state SEL_CH, no commit_pulse.
6. inc+dec in the same cycle -> field unchanged. confirm+cancel in the same cycle -> cancel wins. With N_CH=5, ch_next x5 -> edit_ch returns to 0.
